writeback_sequencer: RTL and testbench
======================================

// Module: writeback_sequencer
// PURPOSE
//   Write-back stage between the ALU/multiplier result path and the register-file write decoder.
//   Accepts one result per valid/ready handshake and converts it into register write cycles.
//   A narrow result (32 b) takes one write cycle; a wide multiplier result (64 b) takes two:
//   the low word goes to dest, the high word to dest+1.
//   Drives the decoder's 3-bit address and write-enable plus the matching write data.
// PARAMETERS
//   DATA_WIDTH  32  register width; a wide result is 2*DATA_WIDTH
//   ADDR_WIDTH  3   register address width (2**ADDR_WIDTH registers)
// PORTS
//   clk       in   1             clock; all state updates on rising edge
//   reset     in   1             synchronous, active-high reset
//   in_valid  in   1             result available on in_* this cycle
//   in_ready  out  1             sequencer accepts a result this cycle
//   in_dest   in   ADDR_WIDTH    destination register (low word for wide results)
//   in_wide   in   1             1 = 64-bit multiplier result, 0 = 32-bit result
//   in_data   in   2*DATA_WIDTH  result; only [DATA_WIDTH-1:0] is used when in_wide=0
//   Addr      out  ADDR_WIDTH    register address to the write decoder (registered)
//   we        out  1             write enable to the write decoder (registered)
//   wdata     out  DATA_WIDTH    data for the addressed register (registered)
//   busy      out  1             1 when state != IDLE
// BEHAVIOUR
//   - Reset (sync, high): state=IDLE, we=0, Addr=0, wdata=0, captured regs=0.
//   - in_ready is 0 while reset is high.
//   - Handshake: a transfer occurs on a rising edge where in_valid & in_ready. In that case
//     in_dest, in_wide and in_data are captured.
//   - Producer must hold in_* stable while in_valid=1 and in_ready=0.
//   - States:
//     - IDLE: we=0, in_ready=1. On transfer -> WR_LO.
//     - WR_LO: we=1, Addr=dest_q, wdata=data_q[DW-1:0].
//       - If wide_q=1: in_ready=0, next state WR_HI.
//       - If wide_q=0: in_ready=1; next state WR_LO on a transfer, else IDLE.
//     - WR_HI: we=1, Addr=dest_q+1 (mod 2**ADDR_WIDTH), wdata=data_q[2*DW-1:DW], in_ready=1.
//       Next state WR_LO on a transfer, else IDLE.
//   - in_ready is combinational from state and wide_q only; it never depends on in_valid.
//   - Latency: a result accepted at edge N gives its first write cycle (we=1) in cycle N+1.
//     A wide result's second write cycle follows in N+2.
//   - Throughput: back-to-back narrow results give one write per cycle with no bubble.
//     Wide results give two writes per result with no bubble between results.
//   - Address wrap: wide with dest=7 writes the low word to 7 and the high word to 0
//     (ADDR_WIDTH bits, carry dropped).
//   - Exactly one register is written per cycle; we=0 in every IDLE cycle.
//   - Simultaneous events: a transfer in the last write cycle of a result is legal. The new
//     result's data is captured on the same edge that retires the current write.
//   - Reset mid-operation: any pending write (including an unissued high word) is dropped.
//     we=0 from the next edge.
//   - in_valid=0 in IDLE: outputs hold; Addr/wdata keep their last values with we=0.
// TESTING
//   - Reset then idle: reset high for 2 cycles -> we=0, Addr=0, wdata=0, busy=0. After
//     release in_ready=1.
//   - Narrow write: in_dest=3, in_wide=0, in_data[31:0]=0xDEADBEEF, 1 beat -> next cycle
//     we=1, Addr=3, wdata=0xDEADBEEF. The cycle after: we=0, busy=0.
//   - Wide write: dest=2, data=0x11112222_33334444 -> Addr=2/wdata=0x33334444, then
//     Addr=3/wdata=0x11112222. in_ready=0 during the first cycle.
//   - Wrap: wide with dest=7, data=0xAAAAAAAA_55555555 -> Addr=7/0x55555555, then
//     Addr=0/0xAAAAAAAA.
//   - Back-to-back narrow with in_valid held high, dests 0,1,2,3 -> we=1 for 4 consecutive
//     cycles, Addr=0,1,2,3, no bubbles.
//   - Reset mid-wide: reset asserted during the WR_LO cycle of a wide write -> no WR_HI
//     cycle, we=0 next cycle, state=IDLE.

Source files
------------

// File: rtl/writeback_sequencer.sv
// Write-back sequencer: turns one accepted ALU/multiplier result into register
// write cycles for the register-file write decoder. A narrow result takes one
// write cycle. A wide result takes two: the low word goes to dest, then the
// high word goes to dest+1, with the address wrapping modulo 2**ADDR_WIDTH.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   in_valid/in_ready   result handshake (in_ready depends only on state and wide_q)
//   in_dest/in_wide     destination register and wide-result flag
//   in_data             result, 2*DATA_WIDTH bits (low half only when narrow)
//   Addr/we/wdata       registered write-decoder address, enable and data
//   busy                high whenever the sequencer is not idle
module writeback_sequencer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDR_WIDTH-1:0]   in_dest,
    input  logic                    in_wide,
    input  logic [2*DATA_WIDTH-1:0] in_data,
    output logic [ADDR_WIDTH-1:0]   Addr,
    output logic                    we,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic                    busy
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned AW = ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   dest_q,  dest_d;
    logic            wide_q,  wide_d;
    logic [2*DW-1:0] data_q,  data_d;
    logic [AW-1:0]   addr_q,  addr_d;
    logic            we_q,    we_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            xfer;
    logic            load;

    // Only the low-word cycle of a wide result refuses new input.
    always_comb begin
        in_ready = 1'b0;
        if (!reset) begin
            in_ready = !((state_q == WR_LO) && wide_q);
        end
    end

    assign xfer = in_valid && in_ready;

    // Next-state and registered-output computation; outputs are set up one
    // cycle ahead so that we/Addr/wdata line up with the state they belong to.
    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        wide_d  = wide_q;
        data_d  = data_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        load    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    load = 1'b1;
                end
            end
            WR_LO: begin
                if (wide_q) begin
                    state_d = WR_HI;
                    we_d    = 1'b1;
                    addr_d  = AW'(dest_q + 1'b1);
                    wdata_d = data_q[2*DW-1:DW];
                end else if (xfer) begin
                    load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_HI: begin
                if (xfer) begin
                    load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new result starts with its low-word write on the next cycle.
        if (load) begin
            state_d = WR_LO;
            dest_d  = in_dest;
            wide_d  = in_wide;
            data_d  = in_data;
            addr_d  = in_dest;
            we_d    = 1'b1;
            wdata_d = in_data[DW-1:0];
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dest_q  <= '0;
            wide_q  <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            wide_q  <= wide_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

    assign Addr  = addr_q;
    assign we    = we_q;
    assign wdata = wdata_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_writeback_sequencer.sv
// Directed bench for writeback_sequencer with hand-computed expected values.
module tb_writeback_sequencer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_dest;
    logic        in_wide;
    logic [63:0] in_data;
    logic [2:0]  Addr;
    logic        we;
    logic [31:0] wdata;
    logic        busy;

    int unsigned n_checks;
    int unsigned n_errors;

    writeback_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_dest  (in_dest),
        .in_wide  (in_wide),
        .in_data  (in_data),
        .Addr     (Addr),
        .we       (we),
        .wdata    (wdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wr(input string tag, input logic [2:0] a, input logic [31:0] d);
        check({tag, ".we"},    64'(we),    64'd1);
        check({tag, ".addr"},  64'(Addr),  64'(a));
        check({tag, ".wdata"}, 64'(wdata), 64'(d));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_dest  = '0;
        in_wide  = 1'b0;
        in_data  = '0;

        // Reset then idle
        step();
        step();
        check("rst.we",    64'(we),       64'd0);
        check("rst.addr",  64'(Addr),     64'd0);
        check("rst.wdata", 64'(wdata),    64'd0);
        check("rst.busy",  64'(busy),     64'd0);
        check("rst.ready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        #1;
        check("idle.ready", 64'(in_ready), 64'd1);

        // Narrow write
        in_valid = 1'b1; in_dest = 3'd3; in_wide = 1'b0; in_data = 64'h0000_0000_DEAD_BEEF;
        step();
        in_valid = 1'b0;
        check_wr("nar", 3'd3, 32'hDEAD_BEEF);
        check("nar.busy",  64'(busy),     64'd1);
        check("nar.ready", 64'(in_ready), 64'd1);
        step();
        check("nar_end.we",    64'(we),    64'd0);
        check("nar_end.busy",  64'(busy),  64'd0);
        check("nar_end.addr",  64'(Addr),  64'd3);
        check("nar_end.wdata", 64'(wdata), 64'hDEAD_BEEF);

        // Wide write
        in_valid = 1'b1; in_dest = 3'd2; in_wide = 1'b1; in_data = 64'h1111_2222_3333_4444;
        step();
        in_valid = 1'b0;
        check_wr("wlo", 3'd2, 32'h3333_4444);
        check("wlo.ready", 64'(in_ready), 64'd0);
        step();
        check_wr("whi", 3'd3, 32'h1111_2222);
        check("whi.ready", 64'(in_ready), 64'd1);
        step();
        check("wide_end.we", 64'(we), 64'd0);

        // Address wrap on wide result
        in_valid = 1'b1; in_dest = 3'd7; in_wide = 1'b1; in_data = 64'hAAAA_AAAA_5555_5555;
        step();
        in_valid = 1'b0;
        check_wr("wrap_lo", 3'd7, 32'h5555_5555);
        step();
        check_wr("wrap_hi", 3'd0, 32'hAAAA_AAAA);
        step();
        check("wrap_end.we", 64'(we), 64'd0);

        // Back-to-back narrow, in_valid held high
        in_valid = 1'b1; in_wide = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_dest = 3'(i);
            in_data = 64'(32'hC000_0000 + 32'(i));
            step();
            check_wr($sformatf("b2b%0d", i), 3'(i), 32'hC000_0000 + 32'(i));
        end
        in_valid = 1'b0;
        step();
        check("b2b_end.we", 64'(we), 64'd0);

        // Back-to-back wide: next result presented while low word is written
        in_valid = 1'b1; in_dest = 3'd5; in_wide = 1'b1; in_data = 64'hA1A1_A1A1_B2B2_B2B2;
        step();
        in_dest = 3'd1; in_data = 64'hC3C3_C3C3_D4D4_D4D4;
        check_wr("w2a_lo", 3'd5, 32'hB2B2_B2B2);
        check("w2a_lo.ready", 64'(in_ready), 64'd0);
        step();
        check_wr("w2a_hi", 3'd6, 32'hA1A1_A1A1);
        check("w2a_hi.ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        check_wr("w2b_lo", 3'd1, 32'hD4D4_D4D4);
        step();
        check_wr("w2b_hi", 3'd2, 32'hC3C3_C3C3);
        step();
        check("w2_end.we", 64'(we), 64'd0);

        // Reset during low-word cycle of a wide write drops the high word
        in_valid = 1'b1; in_dest = 3'd6; in_wide = 1'b1; in_data = 64'h9999_9999_8888_8888;
        step();
        in_valid = 1'b0;
        check_wr("rmid_lo", 3'd6, 32'h8888_8888);
        reset = 1'b1;
        #1;
        check("rmid.ready", 64'(in_ready), 64'd0);
        step();
        reset = 1'b0;
        check("rmid.we",   64'(we),   64'd0);
        check("rmid.busy", 64'(busy), 64'd0);
        check("rmid.addr", 64'(Addr), 64'd0);
        step();
        check("rmid2.we",  64'(we),   64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
